tnn_neuron_serial: RTL
======================

// Module: tnn_neuron_serial
// PURPOSE
//  Sequential, parametrised ternary-NN neuron.
//  - Accepts one sample of N_IN unsigned IN_W-bit features plus per-feature ternary weights (+1/0/-1).
//  - Accumulates one feature per cycle into a signed sum, then emits a one-bit class decision.
//  - The decision is 1 when the sum is strictly greater than THRESH; the signed margin is also output.
//  - Generalises the fixed 7-input, 2-bit combinational comparator neuron to arbitrary input count,
//    feature width, weight map and threshold. Serial operation trades latency for area.
// PARAMETERS
//  N_IN    7   number of features per sample (>=1)
//  IN_W    2   feature width, unsigned (>=1)
//  THRESH  0   signed decision threshold: m_out = (sum > THRESH)
//  ACC_W   localparam = $clog2(N_IN*(2**IN_W-1)+1)+1; signed accumulator/margin width
// PORTS
//  clk       in   1           clock, rising edge
//  rst_n     in   1           asynchronous active-low reset
//  s_valid   in   1           sample valid
//  s_ready   out  1           sample ready
//  s_data    in   N_IN*IN_W   features; feature i = s_data[i*IN_W +: IN_W]
//  w_pos     in   N_IN        bit i set: feature i weight +1
//  w_neg     in   N_IN        bit i set: feature i weight -1
//  m_valid   out  1           result valid
//  m_ready   in   1           result ready
//  m_out     out  1           decision bit
//  m_margin  out  ACC_W       signed sum (sum of +1 features minus sum of -1 features)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, acc=0, idx=0, m_valid=0, m_out=0, m_margin=0.
//    s_ready is 1 after reset. Any in-flight sample is discarded.
//  - States: IDLE, ACC, DONE.
//  - IDLE:
//    - s_ready=1.
//    - On an edge with s_valid=1: latch s_data, w_pos and w_neg; clear acc and idx; go to ACC.
//  - ACC:
//    - s_ready=0.
//    - Each edge: acc += wt(idx)*feat(idx), then idx++.
//    - wt = +1 if w_pos[idx]&~w_neg[idx]; -1 if w_neg[idx]&~w_pos[idx]; otherwise 0.
//      Both bits set means weight 0.
//    - Features are zero-extended to ACC_W before the add.
//    - On the edge that processes idx==N_IN-1: m_margin <= final sum; m_out <= (final sum > THRESH),
//      signed compare; m_valid <= 1; go to DONE.
//  - DONE:
//    - m_valid=1; m_out and m_margin are held stable until the handshake.
//    - On an edge with m_ready=1: m_valid <= 0; go to IDLE.
//    - m_out and m_margin keep their last values after the handshake.
//  - Latency: accept edge E; m_valid is high after edge E+N_IN.
//    Throughput: one sample per N_IN+2 cycles with m_ready held at 1
//    (one IDLE bubble; no accept while in DONE).
//  - Inputs s_data, w_pos and w_neg are ignored outside the accept edge. The latched copy is used.
//  - Arithmetic: |sum| <= N_IN*(2^IN_W-1), so ACC_W never overflows. No saturation logic is needed.
//  - N_IN=1: ACC lasts exactly one edge.
// TESTING (N_IN=7, IN_W=2, THRESH=0, w_pos=7'b0011001, w_neg=7'b1100110)
//  1. All features = 3 -> m_margin = 9-12 = -3, m_out=0; m_valid rises 7 cycles after accept.
//  2. f0=f3=f4=3, others 0 -> m_margin=+9, m_out=1.
//  3. f0=1, f1=1, others 0 -> m_margin=0, m_out=0 (strict compare boundary).
//     With f0=2: margin +1, out 1.
//  4. Weights w_pos=w_neg=7'h7F, all features 3 -> m_margin=0, m_out=0 (conflicting bits = zero weight).
//  5. Hold m_ready=0 for 5 cycles in DONE -> m_valid, m_out and m_margin stable; s_ready=0.
//     After the handshake, s_ready=1 on the next cycle and the next sample is accepted.
//  6. Assert rst_n=0 mid-ACC (idx=3) -> all outputs reset immediately, with no clock needed.
//     After release, a fresh sample gives the correct result with no residue from the aborted one.

Source files
------------

// File: rtl/tnn_neuron_serial.sv
// Serial ternary-weight neuron: one feature per cycle into a signed sum,
// then a thresholded one-bit decision with the signed margin.
module tnn_neuron_serial #(
    parameter  int N_IN   = 7,
    parameter  int IN_W   = 2,
    parameter  int THRESH = 0,
    localparam int ACC_W  = $clog2(N_IN * (2 ** IN_W - 1) + 1) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [N_IN*IN_W-1:0]   s_data,
    input  logic [N_IN-1:0]        w_pos,
    input  logic [N_IN-1:0]        w_neg,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_out,
    output logic signed [ACC_W-1:0] m_margin
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_IN*IN_W-1:0]    data_q;
    logic [N_IN-1:0]         pos_q;
    logic [N_IN-1:0]         neg_q;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] feat_x;
    logic [IN_W-1:0]         feat;
    logic                    last;

    assign last = (idx == IDX_W'(N_IN - 1));

    // Conflicting weight bits (both set) fall through as a zero weight.
    always_comb begin
        feat     = data_q[idx*IN_W +: IN_W];
        feat_x   = ACC_W'(feat);
        acc_next = acc;
        if (pos_q[idx] && !neg_q[idx]) begin
            acc_next = acc + feat_x;
        end else if (neg_q[idx] && !pos_q[idx]) begin
            acc_next = acc - feat_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            pos_q    <= '0;
            neg_q    <= '0;
            idx      <= '0;
            acc      <= '0;
            m_valid  <= 1'b0;
            m_out    <= 1'b0;
            m_margin <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        data_q <= s_data;
                        pos_q  <= w_pos;
                        neg_q  <= w_neg;
                        idx    <= '0;
                        acc    <= '0;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last) begin
                        m_margin <= acc_next;
                        m_out    <= (int'(acc_next) > THRESH);
                        m_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
